// File: rtl/binoc_output_port_rr.sv
// BiNoC router output port: round-robin arbitration over the input ports with
// wormhole locking, driving one downstream req/gnt handshake over NUM_CH channels.
//
// state | meaning
// IDLE  | choosing a winner input and a free channel for the next flit
// SEND  | flit presented downstream, waiting for gnt_dn
module binoc_output_port_rr #(
    parameter int NUM_IN = 10,
    parameter int DATA_W = 32,
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_IN-1:0]                        req_in,
    input  logic [NUM_IN-1:0]                        last_in,
    input  logic [NUM_IN*DATA_W-1:0]                 data_in,
    output logic [NUM_IN-1:0]                        gnt_in,
    input  logic [NUM_CH-1:0]                        ch_full,
    output logic                                     req_dn,
    input  logic                                     gnt_dn,
    output logic [DATA_W-1:0]                        data_dn,
    output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] ch_sel_dn,
    output logic                                     locked,
    output logic [CNT_W-1:0]                         sent_cnt
);

    localparam int IN_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [IN_W-1:0]   ptr;
    logic [IN_W-1:0]   cur_w;
    logic [IN_W-1:0]   lock_in;
    logic [CH_W-1:0]   lock_ch;
    logic              lock_valid;
    logic              tail;

    logic              win_found;
    logic [IN_W-1:0]   win_idx;
    logic              ch_found;
    logic [CH_W-1:0]   ch_idx;
    logic              take;
    logic              done;
    logic [NUM_IN-1:0] gnt_nxt;

    // Winner: a held wormhole lock pins both the input and the channel.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        if (lock_valid) begin
            win_found = req_in[lock_in];
            win_idx   = lock_in;
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                if (!win_found && req_in[(int'(ptr) + k) % NUM_IN]) begin
                    win_found = 1'b1;
                    win_idx   = IN_W'((int'(ptr) + k) % NUM_IN);
                end
            end
        end
    end

    always_comb begin
        ch_found = 1'b0;
        ch_idx   = '0;
        if (lock_valid) begin
            ch_found = !ch_full[lock_ch];
            ch_idx   = lock_ch;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!ch_found && !ch_full[c]) begin
                    ch_found = 1'b1;
                    ch_idx   = CH_W'(c);
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        done      = 1'b0;
        gnt_nxt   = '0;
        case (state)
            IDLE: begin
                if (win_found && ch_found) begin
                    take             = 1'b1;
                    gnt_nxt[win_idx] = 1'b1;
                    state_nxt        = SEND;
                end
            end
            SEND: begin
                if (gnt_dn) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= '0;
            cur_w      <= '0;
            lock_in    <= '0;
            lock_ch    <= '0;
            lock_valid <= 1'b0;
            tail       <= 1'b0;
            req_dn     <= 1'b0;
            data_dn    <= '0;
            ch_sel_dn  <= '0;
            gnt_in     <= '0;
            sent_cnt   <= '0;
        end else begin
            state  <= state_nxt;
            gnt_in <= gnt_nxt;
            if (take) begin
                data_dn   <= data_in[int'(win_idx)*DATA_W +: DATA_W];
                ch_sel_dn <= ch_idx;
                tail      <= last_in[win_idx];
                cur_w     <= win_idx;
                req_dn    <= 1'b1;
            end
            if (done) begin
                req_dn   <= 1'b0;
                sent_cnt <= sent_cnt + CNT_W'(1);
                if (tail) begin
                    lock_valid <= 1'b0;
                    ptr        <= (cur_w == IN_W'(NUM_IN - 1)) ? '0 : cur_w + IN_W'(1);
                end else begin
                    lock_valid <= 1'b1;
                    lock_in    <= cur_w;
                    lock_ch    <= ch_sel_dn;
                end
            end
        end
    end

    assign locked = lock_valid;

endmodule
